// File: rtl/ifu_pkg.sv
// Shared widths, reset PC and the fetch buffer entry type for the instruction fetch unit.
package ifu_pkg;

  localparam int                  IFU_ADDR_W   = 8;
  localparam int                  IFU_DATA_W   = 32;
  localparam logic [IFU_ADDR_W-1:0] IFU_RESET_PC = 8'h00;

  typedef struct packed {
    logic [IFU_ADDR_W-1:0] pc;
    logic [IFU_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO of fetch entries absorbing the ROM read latency; flush beats push and pop.
module fetch_skid_fifo
  import ifu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != 2'd0);

  // NOTE: storage is reset too, so the head reads as zero out of reset; two
  // entries make this cheap, but larger memories should stay un-reset.
  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head = mem[rd_ptr];

  // Upstream credit accounting must never let a push land on a full buffer.
  no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(do_push && !do_pop && count == 2'd2));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues pROM reads and hands {pc, instr} to decode.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                ADDR_W   = IFU_ADDR_W,
  parameter int                DATA_W   = IFU_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = IFU_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] rom_ad,
  output logic              rom_ce,
  output logic              rom_oce,
  output logic              rom_reset,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  logic [ADDR_W-1:0] pc_q;
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic [1:0]        count;
  logic [2:0]        credit_used;
  logic              issue;
  fetch_entry_t      head;
  fetch_entry_t      resp_entry;

  // Credit counts only registered state; a pop this cycle frees a slot next cycle.
  assign credit_used = {1'b0, count} + {2'b0, inflight_q};
  assign issue       = !reset && run && !redirect_valid && (credit_used < 3'd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q       <= redirect_pc;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + 1'b1;
      end
    end
  end

  assign resp_entry = '{pc: inflight_pc_q, instr: rom_dout};

  fetch_skid_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_q && !redirect_valid),
    .push_data (resp_entry),
    .pop       (instr_valid && instr_ready && !redirect_valid),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

  assign rom_ad      = pc_q;
  assign rom_ce      = issue;
  assign rom_oce     = 1'b1;
  assign rom_reset   = reset;
  assign instr_valid = (count != 2'd0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random run/ready/redirect traffic.
module tb_instr_fetch_unit;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic [7:0]  rom_ad;
  logic        rom_ce;
  logic        rom_oce;
  logic        rom_reset;
  logic [31:0] rom_dout;
  logic        instr_valid;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: next PC, the one outstanding read, and the PCs waiting for decode.
  logic [7:0] m_pc;
  bit         m_infl;
  logic [7:0] m_infl_pc;
  logic [7:0] m_q[$];

  instr_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_ad         (rom_ad),
    .rom_ce         (rom_ce),
    .rom_oce        (rom_oce),
    .rom_reset      (rom_reset),
    .rom_dout       (rom_dout),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, one-cycle latency: word n holds 32'hC000_0000 | n.
  always @(posedge clk) begin
    if (rom_ce) rom_dout <= 32'hC000_0000 | {24'd0, rom_ad};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc      = IFU_RESET_PC;
    m_infl    = 1'b0;
    m_infl_pc = IFU_RESET_PC;
    m_q.delete();
  endtask

  task automatic check_reset_values();
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_rom_ce",      rom_ce,      1'b0);
    check("rst_rom_ad",      rom_ad,      IFU_RESET_PC);
    check("rst_instr",       instr,       32'h0);
    check("rst_instr_pc",    instr_pc,    8'h0);
    check("rst_rom_oce",     rom_oce,     1'b1);
    check("rst_rom_reset",   rom_reset,   1'b1);
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance the model at the edge.
  task automatic cycle(input logic r, input logic rd, input logic rv, input logic [7:0] rp);
    logic exp_ce;
    bit   pop;
    run            = r;
    instr_ready    = rd;
    redirect_valid = rv;
    redirect_pc    = rp;
    #1;
    exp_ce = r && !rv && ((m_q.size() + int'(m_infl)) < 2);
    check("rom_ce",      rom_ce,      exp_ce);
    check("rom_ad",      rom_ad,      m_pc);
    check("rom_reset",   rom_reset,   1'b0);
    check("instr_valid", instr_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      check("instr_pc", instr_pc, m_q[0]);
      check("instr",    instr,    32'hC000_0000 | {24'd0, m_q[0]});
    end
    @(posedge clk);
    pop = (m_q.size() > 0) && rd;
    if (rv) begin
      m_q.delete();
      m_infl = 1'b0;
      m_pc   = rp;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_infl_pc);
      m_infl = exp_ce;
      if (exp_ce) begin
        m_infl_pc = m_pc;
        m_pc      = m_pc + 8'd1;
      end
    end
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    run            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    instr_ready    = 1'b0;
    model_reset();
    #3;
    check_reset_values();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Free run from reset, then stall decode for 5 cycles after the first valid.
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 8'h00);

    // Build one buffered entry plus one in flight, then redirect to 8'h40.
    cycle(1'b1, 1'b0, 1'b1, 8'h03);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 1'b1, 8'h40);
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 8'h00);

    // PC wrap through 8'hFF.
    cycle(1'b1, 1'b1, 1'b1, 8'hFE);
    repeat (10) cycle(1'b1, 1'b1, 1'b0, 8'h00);

    // Stop fetch mid-stream, then resume.
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 8'h00);

    // Asynchronous reset between edges.
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 8'h00);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 8'h00);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 9) != 0),
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 19) == 0),
            8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
